dmem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port data memory between the core load/store unit (port 0) and a secondary master such as debug or DMA (port 1). It grants at most one request per cycle and forwards the winner's command to the memory. It tracks the in-flight transaction so that each response returns only to the master that issued it. It also makes write completion explicit, because the memory pulses rvalid only on reads.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter_rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
// Master ids and the single-slot response tracker.
package dmem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef logic master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
    logic       we;
  } resp_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant with priority register.
// The last winner drops to lowest priority on the next cycle.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt,
  output master_id_t             win
);

  master_id_t prio;

  // grant the lone requester, or the prioritised one on contention
  always_comb begin
    gnt[0] = req[0] & (~req[1] | (prio == 1'b0));
    gnt[1] = req[1] & (~req[0] | (prio == 1'b1));
    win    = gnt[1];
  end

  // hand priority to the other port after every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (|gnt) begin
      prio <= ~win;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between LSU and debug/DMA.
// Optional stall counters: define DMEM_ARB_STALL_CNT_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              m_req,
  input  logic [1:0]              m_we,
  input  logic [DATA_WIDTH/8-1:0] m_be0,
  input  logic [DATA_WIDTH/8-1:0] m_be1,
  input  logic [ADDR_WIDTH-1:0]   m_addr0,
  input  logic [ADDR_WIDTH-1:0]   m_addr1,
  input  logic [DATA_WIDTH-1:0]   m_wdata0,
  input  logic [DATA_WIDTH-1:0]   m_wdata1,
  output logic [1:0]              m_gnt,
  output logic [1:0]              m_rvalid,
  output logic [DATA_WIDTH-1:0]   m_rdata0,
  output logic [DATA_WIDTH-1:0]   m_rdata1,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [CNT_WIDTH-1:0]    stall_cnt0,
  output logic [CNT_WIDTH-1:0]    stall_cnt1
);

  master_id_t sel;
  resp_t      resp;
  logic       fire;
  logic       rd_ok;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (m_req),
    .gnt   (m_gnt),
    .win   (sel)
  );

  // forward the winner's command; idle selects port 0, no write
  always_comb begin
    mem_req   = |m_req;
    mem_we    = mem_req & (sel ? m_we[1] : m_we[0]);
    mem_be    = sel ? m_be1    : m_be0;
    mem_addr  = sel ? m_addr1  : m_addr0;
    mem_wdata = sel ? m_wdata1 : m_wdata0;
  end

  // remember who owns the response due next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp <= '0;
    end else begin
      resp.valid <= |m_gnt;
      resp.id    <= sel;
      resp.we    <= mem_we;
    end
  end

  // writes complete on their own; reads wait for memory
  always_comb begin
    rd_ok       = resp.valid & ~resp.we & mem_rvalid;
    fire        = (resp.valid & resp.we) | rd_ok;
    m_rvalid[0] = fire & (resp.id == 1'b0);
    m_rvalid[1] = fire & (resp.id == 1'b1);
    m_rdata0    = (m_rvalid[0] & ~resp.we) ? mem_rdata : '0;
    m_rdata1    = (m_rvalid[1] & ~resp.we) ? mem_rdata : '0;
  end

  // memory must only answer the read issued last cycle
  a_no_stray_rvalid : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(mem_rvalid && !(resp.valid && !resp.we))
  );

`ifdef DMEM_ARB_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_stall
    // count cycles spent waiting, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[i] <= '0;
      end else if (m_req[i] & ~m_gnt[i] & ~&cnt[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign stall_cnt0 = cnt[0];
  assign stall_cnt1 = cnt[1];
`else
  assign stall_cnt0 = '0;
  assign stall_cnt1 = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// Directed vectors; behavioural 1-cycle memory responder.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [1:0]    m_req;
  logic [1:0]    m_we;
  logic [3:0]    m_be0, m_be1;
  logic [AW-1:0] m_addr0, m_addr1;
  logic [DW-1:0] m_wdata0, m_wdata1;
  logic [1:0]    m_gnt;
  logic [1:0]    m_rvalid;
  logic [DW-1:0] m_rdata0, m_rdata1;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] stall_cnt0, stall_cnt1;

  dmem_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_be0      (m_be0),
    .m_be1      (m_be1),
    .m_addr0    (m_addr0),
    .m_addr1    (m_addr1),
    .m_wdata0   (m_wdata0),
    .m_wdata1   (m_wdata1),
    .m_gnt      (m_gnt),
    .m_rvalid   (m_rvalid),
    .m_rdata0   (m_rdata0),
    .m_rdata1   (m_rdata1),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall_cnt0 (stall_cnt0),
    .stall_cnt1 (stall_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [1024];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rvalid  <= 1'b0;
      mem_rdata   <= '0;
      mem[10'h001] <= 32'h1111_1111;
      mem[10'h002] <= 32'h2222_2222;
      mem[10'h010] <= 32'hDEAD_BEEF;
      mem[10'h020] <= 32'hAAAA_AAAA;
    end else begin
      mem_rvalid <= mem_req & ~mem_we;
      if (mem_req & ~mem_we) mem_rdata <= mem[mem_addr];
      if (mem_req & mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b])
            mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic [1:0]    rv;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input logic [1:0] rv,
                      input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1);
    exp_t e;
    e.rv = rv;
    e.d0 = d0;
    e.d1 = d1;
    q.push_back(e);
  endtask

  task automatic chk(input string n,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] egnt, input string n);
    @(negedge clk);
    chk(n, {30'd0, m_gnt}, {30'd0, egnt});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // monitor: every response is popped and compared
  always @(negedge clk) begin
    if (m_rvalid != 2'b00) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL stray_resp rv=%b d0=%h d1=%h",
                 m_rvalid, m_rdata0, m_rdata1);
      end else begin
        e = q.pop_front();
        if (m_rvalid !== e.rv || m_rdata0 !== e.d0 ||
            m_rdata1 !== e.d1) begin
          bad++;
          $display("FAIL resp got=%b/%h/%h exp=%b/%h/%h",
                   m_rvalid, m_rdata0, m_rdata1,
                   e.rv, e.d0, e.d1);
        end
      end
    end
  end

  logic [CW-1:0] exp_sat;
  logic [CW-1:0] exp_three;

  initial begin
`ifdef DMEM_ARB_STALL_CNT_EN
    exp_sat   = '1;
    exp_three = 4'd3;
`else
    exp_sat   = '0;
    exp_three = '0;
`endif
    rst_n = 1'b0;
    m_req = 2'b00;
    m_we = 2'b00;
    m_be0 = 4'hF;
    m_be1 = 4'hF;
    m_addr0 = '0;
    m_addr1 = '0;
    m_wdata0 = '0;
    m_wdata1 = '0;
    #12;
    chk("rst_rvalid", {30'd0, m_rvalid}, 32'd0);
    chk("rst_rdata0", m_rdata0, 32'd0);
    chk("rst_rdata1", m_rdata1, 32'd0);
    chk("rst_gnt", {30'd0, m_gnt}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_stall0", {28'd0, stall_cnt0}, 32'd0);
    chk("rst_stall1", {28'd0, stall_cnt1}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single master read
    m_req = 2'b01;
    m_addr0 = 10'h010;
    #1;
    chk("single_memreq", {31'd0, mem_req}, 32'd1);
    chk("single_addr", {22'd0, mem_addr}, 32'h010);
    chk("single_we", {31'd0, mem_we}, 32'd0);
    push(2'b01, 32'hDEAD_BEEF, 32'h0);
    cyc(2'b01, "single_gnt");
    m_req = 2'b00;
    cyc(2'b00, "single_idle");

    // contention from reset: 0,1,0,1,0,1
    do_reset();
    m_req = 2'b11;
    m_addr0 = 10'h001;
    m_addr1 = 10'h002;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        push(2'b01, 32'h1111_1111, 32'h0);
        cyc(2'b01, "cont_gnt0");
      end else begin
        push(2'b10, 32'h0, 32'h2222_2222);
        cyc(2'b10, "cont_gnt1");
      end
    end
    m_req = 2'b00;
    cyc(2'b00, "cont_idle");
    chk("cont_stall0", {28'd0, stall_cnt0}, {28'd0, exp_three});
    chk("cont_stall1", {28'd0, stall_cnt1}, {28'd0, exp_three});

    // port 1 partial write, then port 0 reads it back
    m_req = 2'b10;
    m_we = 2'b10;
    m_be1 = 4'b0011;
    m_addr1 = 10'h020;
    m_wdata1 = 32'h1234_5678;
    #1;
    chk("wr_memwe", {31'd0, mem_we}, 32'd1);
    chk("wr_addr", {22'd0, mem_addr}, 32'h020);
    chk("wr_be", {28'd0, mem_be}, 32'h3);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    push(2'b10, 32'h0, 32'h0);
    cyc(2'b10, "wr_gnt");
    m_req = 2'b01;
    m_we = 2'b00;
    m_addr0 = 10'h020;
    push(2'b01, 32'hAAAA_5678, 32'h0);
    cyc(2'b01, "rd_after_wr_gnt");
    m_req = 2'b00;
    cyc(2'b00, "wr_idle");

    // back-to-back reads from different ports
    m_req = 2'b01;
    m_addr0 = 10'h001;
    push(2'b01, 32'h1111_1111, 32'h0);
    cyc(2'b01, "b2b_gnt0");
    m_req = 2'b10;
    m_addr1 = 10'h002;
    push(2'b10, 32'h0, 32'h2222_2222);
    cyc(2'b10, "b2b_gnt1");
    m_req = 2'b00;
    cyc(2'b00, "b2b_idle");

    // reset in the cycle after a read grant drops the response
    m_req = 2'b01;
    m_addr0 = 10'h010;
    cyc(2'b01, "mid_gnt");
    m_req = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("mid_rvalid", {30'd0, m_rvalid}, 32'd0);
    chk("mid_rdata0", m_rdata0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_req = 2'b11;
    m_addr0 = 10'h001;
    m_addr1 = 10'h002;
    push(2'b01, 32'h1111_1111, 32'h0);
    cyc(2'b01, "mid_prio0");
    m_req = 2'b10;
    push(2'b10, 32'h0, 32'h2222_2222);
    cyc(2'b10, "mid_then1");
    m_req = 2'b00;
    cyc(2'b00, "mid_idle");

    // long contention saturates both counters
    do_reset();
    m_req = 2'b11;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        push(2'b01, 32'h1111_1111, 32'h0);
        cyc(2'b01, "sat_gnt0");
      end else begin
        push(2'b10, 32'h0, 32'h2222_2222);
        cyc(2'b10, "sat_gnt1");
      end
    end
    chk("sat_stall1", {28'd0, stall_cnt1}, {28'd0, exp_sat});
    chk("sat_stall0", {28'd0, stall_cnt0}, {28'd0, exp_sat});
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push(2'b01, 32'h1111_1111, 32'h0);
        cyc(2'b01, "hold_gnt0");
      end else begin
        push(2'b10, 32'h0, 32'h2222_2222);
        cyc(2'b10, "hold_gnt1");
      end
    end
    chk("hold_stall1", {28'd0, stall_cnt1}, {28'd0, exp_sat});
    m_req = 2'b00;
    cyc(2'b00, "end_idle0");
    cyc(2'b00, "end_idle1");
    chk("queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
